// File: rtl/cp_insert_pkg.sv
// -----------------------------------------------------------------------------
// cp_insert_pkg
// Shared constants, types and helpers for the cyclic-prefix insertion block:
// FFT size limits, buffer address width, reference CP lengths, read-side FSM
// state encoding, LOW/HIGH literals, and the fft_num / cp_num calculators.
// -----------------------------------------------------------------------------
package cp_insert_pkg;

  localparam int FFT_MAX_NUM    = 2048;
  localparam int FFT_NUM_NBIT   = 12;
  localparam int BUF_ADDR_NBIT  = 11;   // one bank holds FFT_MAX_NUM samples

  // Reference CP lengths for the largest symbol (normal / normal-first / extended).
  localparam int CP_NOR_NUM     = 144;
  localparam int CP_NOR_FST_NUM = 160;
  localparam int CP_EXT_NUM     = 512;

  localparam logic LOW  = 1'b0;
  localparam logic HIGH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CP   = 2'd1,
    ST_DATA = 2'd2
  } rd_state_t;

  // Per-symbol parameter set, stored once per ping-pong bank.
  typedef struct packed {
    logic [FFT_NUM_NBIT-1:0] fft_num;
    logic [FFT_NUM_NBIT-1:0] cp_num;
    logic                    fst;
  } sym_par_t;

  // 2048 - num_pat*512, done as a subtraction of a shifted pattern.
  function automatic logic [FFT_NUM_NBIT-1:0] fft_num_of(input logic [1:0] num_pat);
    return FFT_NUM_NBIT'(FFT_MAX_NUM) - {1'b0, num_pat, 9'd0};
  endfunction

  // Shift-add CP length with 12-bit truncation; no multiplier needed.
  function automatic logic [FFT_NUM_NBIT-1:0] cp_num_of(
    input logic [FFT_NUM_NBIT-1:0] fft_num,
    input logic                    ext,
    input logic                    fst
  );
    if (ext)      return fft_num >> 2;
    else if (fst) return (fft_num >> 4) + (fft_num >> 6);
    else          return (fft_num >> 4) + (fft_num >> 7);
  endfunction

endpackage

// File: rtl/cp_buf.sv
// -----------------------------------------------------------------------------
// cp_buf
// Simple dual-port RAM holding both ping-pong banks (bank select is the
// address MSB). Registered read; a read and write to the same address in the
// same cycle returns the old contents. Written to infer block RAM.
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address {bank, sample}
//   wr_data  write word {I, Q}
//   rd_en    read strobe (output register loads only when set)
//   rd_addr  read address {bank, sample}
//   rd_data  registered read word, valid the cycle after rd_en
// -----------------------------------------------------------------------------
module cp_buf
  import cp_insert_pkg::*;
#(
  parameter int DATA_NBIT = 30,
  parameter int ADDR_NBIT = BUF_ADDR_NBIT + 1
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_NBIT-1:0] wr_addr,
  input  logic [DATA_NBIT-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_NBIT-1:0] rd_addr,
  output logic [DATA_NBIT-1:0] rd_data
);

  logic [DATA_NBIT-1:0] mem [2**ADDR_NBIT];

  // NOTE: the array has no reset; clearing a RAM would force it into flops.
  // Every location is written before the reader is allowed to touch it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cp_insert.sv
// -----------------------------------------------------------------------------
// cp_insert
// Transmit-side cyclic-prefix insertion. IFFT packets (sop/valid/eop, one
// OFDM symbol each) are stored in a ping-pong buffer and replayed at sample
// rate (one sample every CLK_FS_RATIO clocks) with the CP prepended.
//
// Build option: define CP_EXT_EN to honour cp_type (extended CP). Without it
// cp_type is ignored and every symbol uses the normal CP.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   num_pat             symbol size 0..3 = 2048/1536/1024/512 (latched at sop)
//   cp_type             0 normal, 1 extended (latched at sop)
//   din_fst             first symbol of slot (latched at sop)
//   din_sop/valid/eop   input packet framing
//   din_real/din_imag   IFFT output sample
//   dout_i/dout_q       output sample
//   dout_h              first CP sample of a symbol
//   dout_s              latched din_fst, updated with dout_h and held
//   dout_v              output sample valid (single-clock pulse)
//   dout_err            one-cycle pulse on length error or overflow
// -----------------------------------------------------------------------------
module cp_insert
  import cp_insert_pkg::*;
#(
  parameter int DATA_NBIT    = 15,
  parameter int CLK_FS_RATIO = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           num_pat,
  input  logic                 cp_type,
  input  logic                 din_fst,
  input  logic                 din_sop,
  input  logic                 din_valid,
  input  logic [DATA_NBIT-1:0] din_real,
  input  logic [DATA_NBIT-1:0] din_imag,
  input  logic                 din_eop,
  output logic [DATA_NBIT-1:0] dout_i,
  output logic [DATA_NBIT-1:0] dout_q,
  output logic                 dout_h,
  output logic                 dout_s,
  output logic                 dout_v,
  output logic                 dout_err
);

  localparam int RAM_AW    = BUF_ADDR_NBIT + 1;
  localparam int RAM_DW    = 2 * DATA_NBIT;
  localparam int PACE_NBIT = (CLK_FS_RATIO > 2) ? $clog2(CLK_FS_RATIO) : 1;

  localparam logic [BUF_ADDR_NBIT-1:0] ADDR_ONE = 1;
  localparam logic [FFT_NUM_NBIT-1:0]  CNT_ONE  = 1;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic                    wbank;
  logic [FFT_NUM_NBIT-1:0] waddr;      // samples received in this packet
  logic                    pkt_drop;   // a sample of this packet was refused
  logic [1:0]              pend_np;
  logic                    pend_fst;
  logic                    eff_ext;
  sym_par_t                bank_par [2];
  logic [1:0]              full;
  logic [1:0]              full_d;

`ifdef CP_EXT_EN
  logic pend_ext;
  assign eff_ext = din_sop ? cp_type : pend_ext;
`else
  logic unused_cp_type;
  assign unused_cp_type = cp_type;
  assign eff_ext        = LOW;
`endif

  sym_par_t                in_par;
  logic [FFT_NUM_NBIT-1:0] wr_count;
  logic                    blocked;
  logic                    wr_en;
  logic [RAM_AW-1:0]       wr_addr;
  logic                    eop_ev;
  logic                    sym_ok;
  logic                    sym_bad;

  // A sop sample uses the live inputs, so a one-sample packet sees its own
  // parameters rather than the previous pending set.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    in_par         = '0;
    in_par.fst     = din_sop ? din_fst : pend_fst;
    in_par.fft_num = fft_num_of(din_sop ? num_pat : pend_np);
    in_par.cp_num  = cp_num_of(in_par.fft_num, eff_ext, in_par.fst);
  end

  // A full write bank is still owed to the reader, so writes into it are
  // refused; that guarantees data being replayed is never overwritten.
  assign blocked  = full[wbank];
  assign wr_count = din_sop ? CNT_ONE : waddr + CNT_ONE;
  assign wr_en    = din_valid && !blocked && (din_sop || !waddr[FFT_NUM_NBIT-1]);
  assign wr_addr  = {wbank, din_sop ? {BUF_ADDR_NBIT{1'b0}} : waddr[BUF_ADDR_NBIT-1:0]};
  assign eop_ev   = din_valid && din_eop;
  assign sym_ok   = eop_ev && (wr_count == in_par.fft_num) &&
                    !blocked && !(pkt_drop && !din_sop);
  assign sym_bad  = eop_ev && !sym_ok;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbank       <= LOW;
      waddr       <= '0;
      pkt_drop    <= LOW;
      pend_np     <= 2'd0;
      pend_fst    <= LOW;
`ifdef CP_EXT_EN
      pend_ext    <= LOW;
`endif
      bank_par[0] <= '0;
      bank_par[1] <= '0;
    end else begin
      if (din_valid) begin
        if (din_sop) begin
          waddr    <= CNT_ONE;
          pend_np  <= num_pat;
          pend_fst <= din_fst;
`ifdef CP_EXT_EN
          pend_ext <= cp_type;
`endif
          pkt_drop <= blocked;
        end else begin
          if (waddr != '1) waddr <= waddr + CNT_ONE;   // saturate on runaway packets
          pkt_drop <= pkt_drop | blocked;
        end
        if (din_eop) begin
          waddr    <= '0;
          pkt_drop <= LOW;
        end
      end
      if (sym_ok) begin
        bank_par[wbank] <= in_par;
        wbank           <= ~wbank;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-rate strobe
  // ---------------------------------------------------------------------------
  logic [PACE_NBIT-1:0] pace;
  logic                 stb;

  assign stb = (pace == PACE_NBIT'(CLK_FS_RATIO - 1));

  always_ff @(posedge clk) begin
    if (reset)    pace <= '0;
    else if (stb) pace <= '0;
    else          pace <= pace + 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Read side FSM
  // ---------------------------------------------------------------------------
  rd_state_t               state, state_d;
  logic                    rbank;
  logic                    nrbank;
  logic [BUF_ADDR_NBIT-1:0] raddr;
  logic [FFT_NUM_NBIT-1:0] rcnt;       // reads issued in the current phase
  sym_par_t                cur_par;
  logic                    cp_first;   // next CP read is the symbol's first
  sym_par_t                rd_par;
  sym_par_t                nxt_par;
  logic                    cp_last;
  logic                    data_last;

  logic                     rd_en;
  logic                     rd_h;
  logic                     rd_done;
  logic                     load_idle;
  logic                     load_next;
  logic [BUF_ADDR_NBIT-1:0] rd_addr;

  assign nrbank    = ~rbank;
  assign rd_par    = bank_par[rbank];
  assign nxt_par   = bank_par[nrbank];
  assign cp_last   = (rcnt == cur_par.cp_num - CNT_ONE);
  assign data_last = (rcnt == cur_par.fft_num - CNT_ONE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (stb && full[rbank]) state_d = ST_CP;
      ST_CP:   if (stb && cp_last)     state_d = ST_DATA;
      ST_DATA: if (stb && data_last)   state_d = full[nrbank] ? ST_CP : ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // The IDLE start issues the first CP read on the same strobe, which keeps
  // eop-to-first-sample latency within one sample period plus the pipeline.
  always_comb begin
    rd_en     = LOW;
    rd_h      = LOW;
    rd_done   = LOW;
    load_idle = LOW;
    load_next = LOW;
    rd_addr   = raddr;
    case (state)
      ST_IDLE: begin
        if (stb && full[rbank]) begin
          rd_en     = HIGH;
          rd_h      = HIGH;
          load_idle = HIGH;
          rd_addr   = BUF_ADDR_NBIT'(rd_par.fft_num - rd_par.cp_num);
        end
      end
      ST_CP: begin
        if (stb) begin
          rd_en = HIGH;
          rd_h  = cp_first;
        end
      end
      ST_DATA: begin
        if (stb) begin
          rd_en = HIGH;
          if (data_last) begin
            rd_done   = HIGH;
            load_next = full[nrbank];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rbank    <= LOW;
      raddr    <= '0;
      rcnt     <= '0;
      cur_par  <= '0;
      cp_first <= LOW;
    end else if (load_idle) begin
      cur_par  <= rd_par;
      raddr    <= rd_addr + ADDR_ONE;
      rcnt     <= CNT_ONE;
      cp_first <= LOW;
    end else if (state == ST_CP && stb) begin
      cp_first <= LOW;
      if (cp_last) begin
        raddr <= '0;
        rcnt  <= '0;
      end else begin
        raddr <= raddr + ADDR_ONE;
        rcnt  <= rcnt + CNT_ONE;
      end
    end else if (state == ST_DATA && stb) begin
      if (data_last) begin
        rbank <= nrbank;
        if (load_next) begin
          cur_par  <= nxt_par;
          raddr    <= BUF_ADDR_NBIT'(nxt_par.fft_num - nxt_par.cp_num);
          rcnt     <= '0;
          cp_first <= HIGH;
        end
      end else begin
        raddr <= raddr + ADDR_ONE;
        rcnt  <= rcnt + CNT_ONE;
      end
    end
  end

  // Reader clears its bank while the writer may fill the other one in the
  // same cycle; the flags are independent so both updates land.
  always_comb begin
    full_d = full;
    if (rd_done) full_d[rbank] = LOW;
    if (sym_ok)  full_d[wbank] = HIGH;
  end

  always_ff @(posedge clk) begin
    if (reset) full <= '0;
    else       full <= full_d;
  end

  // ---------------------------------------------------------------------------
  // Buffer and output pipeline (RAM read register + output register)
  // ---------------------------------------------------------------------------
  logic [RAM_DW-1:0] rd_data;
  logic              v1;
  logic              h1;

  cp_buf #(
    .DATA_NBIT (RAM_DW),
    .ADDR_NBIT (RAM_AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({din_real, din_imag}),
    .rd_en   (rd_en),
    .rd_addr ({rbank, rd_addr}),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      v1       <= LOW;
      h1       <= LOW;
      dout_v   <= LOW;
      dout_h   <= LOW;
      dout_s   <= LOW;
      dout_err <= LOW;
      dout_i   <= '0;
      dout_q   <= '0;
    end else begin
      v1       <= rd_en;
      h1       <= rd_h;
      dout_v   <= v1;
      dout_h   <= h1;
      dout_err <= sym_bad;
      if (v1) begin
        dout_i <= rd_data[RAM_DW-1:DATA_NBIT];
        dout_q <= rd_data[DATA_NBIT-1:0];
      end
      // cur_par has been reloaded by the time the first CP word gets here.
      if (h1) dout_s <= cur_par.fst;
    end
  end

endmodule

// File: tb/tb_cp_insert.sv
// -----------------------------------------------------------------------------
// tb_cp_insert
// Directed bench for cp_insert. A symbol-level model turns every accepted
// packet into its expected output list (CP tail copy, then the symbol) and a
// single compare process checks each dout_v sample against it, including the
// sample spacing. Literal expectations pin CP start points and lengths.
// -----------------------------------------------------------------------------
module tb_cp_insert;

  localparam int DATA_NBIT = 15;
  localparam int RATIO     = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           num_pat;
  logic                 cp_type;
  logic                 din_fst;
  logic                 din_sop;
  logic                 din_valid;
  logic [DATA_NBIT-1:0] din_real;
  logic [DATA_NBIT-1:0] din_imag;
  logic                 din_eop;
  logic [DATA_NBIT-1:0] dout_i;
  logic [DATA_NBIT-1:0] dout_q;
  logic                 dout_h;
  logic                 dout_s;
  logic                 dout_v;
  logic                 dout_err;

  cp_insert #(
    .DATA_NBIT    (DATA_NBIT),
    .CLK_FS_RATIO (RATIO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .num_pat   (num_pat),
    .cp_type   (cp_type),
    .din_fst   (din_fst),
    .din_sop   (din_sop),
    .din_valid (din_valid),
    .din_real  (din_real),
    .din_imag  (din_imag),
    .din_eop   (din_eop),
    .dout_i    (dout_i),
    .dout_q    (dout_q),
    .dout_h    (dout_h),
    .dout_s    (dout_s),
    .dout_v    (dout_v),
    .dout_err  (dout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DATA_NBIT-1:0] i;
    logic [DATA_NBIT-1:0] q;
    logic                 h;
    logic                 s;
    logic                 gap;   // check spacing to the previous sample
  } exp_t;

  exp_t exp_q[$];
  int   h_vals[$];
  int   checks    = 0;
  int   errors    = 0;
  int   out_count = 0;
  int   err_seen  = 0;
  int   last_v    = 0;
  int   h_cyc     = 0;
  int   eop_cyc   = 0;
  int   out_base;
  int   err_base;
  exp_t e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DATA_NBIT-1:0] samp_i(input int base, input int n);
    return DATA_NBIT'(base + n);
  endfunction

  function automatic logic [DATA_NBIT-1:0] samp_q(input int base, input int n);
    return DATA_NBIT'(n * 7 + base * 3 + 3);
  endfunction

  // Symbol-level model: CP length from the plain size/type rules.
  task automatic push_pkt(input logic [1:0] np, input logic ct, input logic fst,
                          input int len, input int base, input bit accept,
                          input bit gap_first);
    int fft;
    int cp;
    bit ext;
    exp_t x;
    fft = 2048 - 512 * int'(np);
`ifdef CP_EXT_EN
    ext = ct;
`else
    ext = 1'b0;
`endif
    if (ext)      cp = fft / 4;
    else if (fst) cp = fft / 16 + fft / 64;
    else          cp = fft / 16 + fft / 128;
    if (accept) begin
      for (int k = 0; k < cp; k++) begin
        x.i = samp_i(base, fft - cp + k);
        x.q = samp_q(base, fft - cp + k);
        x.h = (k == 0);
        x.s = fst;
        x.gap = (k == 0) ? gap_first : 1'b1;
        exp_q.push_back(x);
      end
      for (int n = 0; n < fft; n++) begin
        x.i = samp_i(base, n);
        x.q = samp_q(base, n);
        x.h = 1'b0;
        x.s = fst;
        x.gap = 1'b1;
        exp_q.push_back(x);
      end
    end
    for (int n = 0; n < len; n++) begin
      @(posedge clk); #1;
      din_valid = 1'b1;
      din_sop   = (n == 0);
      din_eop   = (n == len - 1);
      din_real  = samp_i(base, n);
      din_imag  = samp_q(base, n);
      num_pat   = np;
      cp_type   = ct;
      din_fst   = fst;
    end
    eop_cyc = cyc + 1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    din_sop   = 1'b0;
    din_eop   = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 30000) begin
      @(negedge clk);
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    repeat (40) @(negedge clk);
  endtask

  task automatic start_test();
    out_base = out_count;
    err_base = err_seen;
    h_vals.delete();
  endtask

  // Compare process: every output sample against the model.
  always @(negedge clk) begin
    if (!reset && dout_v) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got i=%0d expected no sample (cycle %0d)", dout_i, cyc);
      end else begin
        e = exp_q.pop_front();
        check("dout_i", dout_i, e.i);
        check("dout_q", dout_q, e.q);
        check("dout_h", dout_h, e.h);
        check("dout_s", dout_s, e.s);
        if (e.gap) check("sample_spacing", cyc - last_v, RATIO);
      end
      if (dout_h) begin
        h_vals.push_back(int'(dout_i));
        h_cyc = cyc;
      end
      last_v = cyc;
      out_count++;
    end
    if (dout_err) err_seen++;
  end

  initial begin
    reset     = 1'b1;
    num_pat   = 2'd0;
    cp_type   = 1'b0;
    din_fst   = 1'b0;
    din_sop   = 1'b0;
    din_valid = 1'b0;
    din_eop   = 1'b0;
    din_real  = '0;
    din_imag  = '0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_dout_v", dout_v, 0);
    check("rst_dout_h", dout_h, 0);
    check("rst_dout_err", dout_err, 0);
    check("rst_dout_i", dout_i, 0);
    reset = 1'b0;

    // 1: 2048 normal first-of-slot ramp -> 160 CP from 1888, then 0..2047.
    start_test();
    push_pkt(2'd0, 1'b0, 1'b1, 2048, 0, 1'b1, 1'b0);
    drain("t1");
    check("t1_count", out_count - out_base, 2208);
    check("t1_cp_start", h_vals.size() > 0 ? h_vals[0] : -1, 1888);
    check("t1_latency_ok", (h_cyc - eop_cyc) <= RATIO + 2, 1);
    check("t1_err", err_seen - err_base, 0);

    // 2: 512 with cp_type=1 (extended only when the option is built).
    start_test();
    push_pkt(2'd3, 1'b1, 1'b0, 512, 0, 1'b1, 1'b0);
    drain("t2");
`ifdef CP_EXT_EN
    check("t2_count", out_count - out_base, 640);
    check("t2_cp_start", h_vals.size() > 0 ? h_vals[0] : -1, 384);
`else
    check("t2_count", out_count - out_base, 548);
    check("t2_cp_start", h_vals.size() > 0 ? h_vals[0] : -1, 476);
`endif

    // 3: two back-to-back 1536 normal symbols, CP 108 from 1428, no gap.
    start_test();
    push_pkt(2'd1, 1'b0, 1'b0, 1536, 0, 1'b1, 1'b0);
    push_pkt(2'd1, 1'b0, 1'b0, 1536, 100, 1'b1, 1'b1);
    drain("t3");
    check("t3_count", out_count - out_base, 3288);
    check("t3_cp_start_a", h_vals.size() > 0 ? h_vals[0] : -1, 1428);
    check("t3_cp_start_b", h_vals.size() > 1 ? h_vals[1] : -1, 1528);

    // 4: short packet (100 of 2048) -> error, nothing out; then a good one.
    start_test();
    push_pkt(2'd0, 1'b0, 1'b0, 100, 0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    check("t4_err", err_seen - err_base, 1);
    check("t4_no_output", out_count - out_base, 0);
    push_pkt(2'd3, 1'b0, 1'b0, 512, 7, 1'b1, 1'b0);
    drain("t4");
    check("t4_count", out_count - out_base, 548);
    check("t4_cp_start", h_vals.size() > 0 ? h_vals[0] : -1, 483);

    // 5: three symbols faster than the reader drains -> third overflows.
    start_test();
    push_pkt(2'd3, 1'b0, 1'b1, 512, 10, 1'b1, 1'b0);
    push_pkt(2'd3, 1'b0, 1'b1, 512, 20, 1'b1, 1'b1);
    push_pkt(2'd3, 1'b0, 1'b1, 512, 30, 1'b0, 1'b0);
    drain("t5");
    check("t5_err", err_seen - err_base, 1);
    check("t5_count", out_count - out_base, 1104);
    check("t5_cp_start_a", h_vals.size() > 0 ? h_vals[0] : -1, 482);
    check("t5_cp_start_b", h_vals.size() > 1 ? h_vals[1] : -1, 492);

    // 6: reset in the middle of DATA, then a fresh symbol.
    start_test();
    push_pkt(2'd3, 1'b0, 1'b1, 512, 50, 1'b1, 1'b0);
    begin
      int k;
      k = 0;
      while (out_count < out_base + 60 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check("t6_reached_data", out_count >= out_base + 60, 1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("t6_rst_dout_v", dout_v, 0);
    check("t6_rst_dout_s", dout_s, 0);
    check("t6_rst_dout_i", dout_i, 0);
    check("t6_rst_dout_q", dout_q, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_base = out_count;
    repeat (100) @(negedge clk);
    check("t6_no_output_after_reset", out_count - out_base, 0);
    h_vals.delete();
    push_pkt(2'd3, 1'b0, 1'b0, 512, 60, 1'b1, 1'b0);
    drain("t6");
    check("t6_count", out_count - out_base, 548);
    check("t6_cp_start", h_vals.size() > 0 ? h_vals[0] : -1, 536);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp_insert.md
# cp_insert

Transmit-side counterpart of the FFT precondition stage: it accepts IFFT output packets (sop/valid/eop, one OFDM symbol per packet), buffers each symbol in a ping-pong RAM, and re-emits it at sample rate with the cyclic prefix prepended. Its output uses the same I/Q/first-sample/first-slot/valid format that the receive-side CP-removal stage consumes, so the two blocks form a loopback pair. It sits between the IFFT core and the DAC/radio interface.

## Interface
- DATA_NBIT, 15, I and Q sample width.
- CLK_FS_RATIO, 5, clocks per output sample (must be ≥ 2).
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- num_pat  in  2  symbol size, latched at din_sop: 0=2048, 1=1536, 2=1024, 3=512.
- cp_type  in  1  latched at din_sop: 0=normal, 1=extended.
- din_fst  in  1  latched at din_sop: symbol is the first of its slot (longer normal CP).
- din_sop  in  1  first sample of an IFFT packet; qualified by din_valid.
- din_valid  in  1  input sample valid.
- din_real  in  DATA_NBIT  IFFT real output.
- din_imag  in  DATA_NBIT  IFFT imag output.
- din_eop  in  1  last sample of the packet; qualified by din_valid.
- dout_i  out  DATA_NBIT  I sample.
- dout_q  out  DATA_NBIT  Q sample.
- dout_h  out  1  first CP sample of a symbol.
- dout_s  out  1  copy of the latched din_fst; valid with dout_h and held for the whole symbol.
- dout_v  out  1  sample valid, at most one per CLK_FS_RATIO clocks.
- dout_err  out  1  one-cycle pulse: length error or overflow.

## Operation
- Write side: waddr counts din_valid samples. din_sop&din_valid writes address 0, sets waddr=1, and latches num_pat, cp_type and din_fst into the pending set. A sop that arrives mid-packet restarts the packet and discards the partial data.
- On din_eop&din_valid:
  - If sample count == fft_num: mark the write bank full, copy the pending set to that bank's parameter slot, and toggle the write bank.
  - Otherwise: pulse dout_err and drop the packet. The bank is not toggled.
- fft_num = 2048 − num_pat×512, 12-bit unsigned.
- cp_num is computed by shift-add with 12-bit truncation, no multiplier:
  - normal, first symbol: (fft_num>>4)+(fft_num>>6).
  - normal, other symbols: (fft_num>>4)+(fft_num>>7).
  - extended: fft_num>>2.
  - Resulting values for 2048: 160/144/512. For 1536: 120/108/384.
- Overflow: if eop arrives while the target bank is still full (not yet read out), pulse dout_err and drop the packet. Bank data that is currently being read is never overwritten.
- Read side FSM, which advances only on the sample strobe stb (pacing counter wraps at CLK_FS_RATIO−1):
  - IDLE: if the read bank is full, latch its parameters, set raddr=fft_num−cp_num, go to CP.
  - CP: issue a read, raddr++. After cp_num reads, set raddr=0 and go to DATA.
  - DATA: issue a read, raddr++. After fft_num reads, clear the bank's full flag and toggle the read bank. If the new bank is full, go straight to CP (no gap strobe); otherwise go to IDLE.
- dout_h marks the first CP read. dout_s comes from the bank's latched din_fst.
- If the write side marks a bank full in the same cycle the reader clears it, both take effect; the flags are per-bank.

## Timing
- RAM read is registered (1 cycle) and the output register adds 1 cycle. dout_v/dout_i/dout_q/dout_h appear 2 clocks after the stb on which the read was issued.
- dout_v is high for exactly 1 clock per sample.
- Minimum latency from the input eop (symbol complete) to the first dout_v is 2 clocks after the next stb, i.e. ≤ CLK_FS_RATIO+2 clocks.
- Back-to-back symbols are gapless: consecutive dout_v pulses are exactly CLK_FS_RATIO apart.
- reset: all outputs become 0 on the next clock. The FSM goes to IDLE, both banks are marked empty, both bank pointers return to bank 0, the pacing counter is cleared, and pending parameters go to 2048/normal/not-first. Any symbol in flight is abandoned.

## Configuration
- CP_EXT_EN defined: cp_type is honoured as specified above.
- CP_EXT_EN undefined: cp_type is ignored and always treated as normal. The extended-CP logic is not built.

## Structure
- Shared include (lte_fft_inc.v) holds: FFT_MAX_NUM, FFT_NUM_NBIT, BUF_ADDR_NBIT, CP_NOR_NUM, CP_NOR_FST_NUM, CP_EXT_NUM, the FSM state encodings, and LOW/HIGH.
- Sub-module cp_buf: a simple dual-port RAM of 2×2^BUF_ADDR_NBIT words × 2·DATA_NBIT bits. It is registered-read, returns old data on a simultaneous read and write to the same address, and is inferred as block RAM.

## Test plan
- 2048, normal, din_fst=1, input ramp 0..2047 → 2208 outputs: 1888..2047 then 0..2047. dout_h on the first output only, dout_s=1, spacing exactly 5 clocks.
- 512, extended, ramp 0..511 → 640 outputs: 384..511 then 0..511.
- 1536, normal, din_fst=0 → CP length 108 starting at sample 1428. A back-to-back second symbol follows with no gap.
- eop after 100 samples with num_pat=0 → dout_err pulse and no output. A following valid symbol is emitted correctly.
- Three symbols pushed faster than the read side drains them → third eop gives dout_err, first two symbols are output intact.
- Reset asserted mid-DATA → dout_v=0 on the next clock, no further output. A fresh symbol after reset is emitted from bank 0.
